pipeline_trace_buffer: RTL and testbench

Synthesizable on-chip trace capture for the MIPS pipeline. It samples NUM_CH monitored pipeline signals each valid cycle into a circular buffer, together with a free-running cycle stamp. It stops capturing a programmable number of samples after a trigger match, then streams the captured window out oldest-first over a valid/ready port. It replaces per-cycle $display monitoring with hardware visible to a debug unit.

---
 rtl/pipeline_trace_buffer.sv | 136 +++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer: triggered circular capture of pipeline signals with cycle stamps,
// streamed out oldest-first over a valid/ready port once the post-trigger window is filled.
module pipeline_trace_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH = 4,
    parameter int DEPTH = 64,
    parameter int TS_WIDTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CW = NUM_CH * DATA_WIDTH,
    localparam int RW = CW + TS_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_en,
    input  logic [CW-1:0]         ch_data,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [SW-1:0]         trig_sel,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [1:0]            trig_mode,
    input  logic [7:0]            trig_count,
    input  logic [AW:0]           post_count,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [RW-1:0]         rd_data,
    output logic                  rd_last,
    output logic [2:0]            state,
    output logic [AW:0]           entries,
    output logic [TS_WIDTH-1:0]   trig_stamp
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        POST    = 3'd2,
        DONE    = 3'd3,
        READOUT = 3'd4
    } state_t;

    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t st, nxt;
    logic [RW-1:0] mem [DEPTH];
    logic [TS_WIDTH-1:0] stamp;
    logic [AW-1:0] wr_ptr, rd_ptr, oldest;
    logic [AW:0] remain, rd_cnt, post_clamp;
    logic [7:0] match_cnt;
    logic [8:0] nth;
    logic [DATA_WIDTH-1:0] sel_ch;
    logic raw_match, match, wr_en, hit, xfer;

    assign state      = st;
    assign sel_ch     = ch_data[trig_sel*DATA_WIDTH +: DATA_WIDTH];
    assign raw_match  = ((sel_ch ^ trig_value) & trig_mask) == '0;
    assign nth        = (trig_count == 8'd0) ? 9'd1 : {1'b0, trig_count};
    assign match      = (trig_mode == 2'd0) ||
                        (trig_mode == 2'd1 && raw_match) ||
                        (trig_mode == 2'd2 && raw_match && ({1'b0, match_cnt} + 9'd1 >= nth)) ||
                        (trig_mode == 2'd3 && !raw_match);
    assign post_clamp = (post_count > FULL) ? FULL : post_count;
    assign wr_en      = sample_en && !abort && (st == ARMED || st == POST);
    assign hit        = wr_en && st == ARMED && match;
    assign xfer       = rd_valid && rd_ready;
    // With a full buffer entries[AW-1:0] is zero, so the oldest slot is wr_ptr itself.
    assign oldest     = wr_ptr - entries[AW-1:0];

    always_comb begin
        nxt = st;
        unique case (st)
            IDLE:    nxt = arm ? ARMED : IDLE;
            ARMED:   nxt = hit ? ((post_clamp <= ONE) ? DONE : POST) : ARMED;
            POST:    nxt = (wr_en && remain == ONE) ? DONE : POST;
            DONE:    nxt = READOUT;
            READOUT: nxt = (xfer && rd_last) ? IDLE : READOUT;
            default: nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {stamp, ch_data};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st         <= IDLE;
            stamp      <= '0;
            wr_ptr     <= '0;
            entries    <= '0;
            match_cnt  <= '0;
            trig_stamp <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            remain     <= '0;
            rd_ptr     <= '0;
            rd_cnt     <= '0;
        end else begin
            st    <= nxt;
            stamp <= stamp + 1'b1;
            if (st == IDLE && arm && !abort) begin
                wr_ptr    <= '0;
                entries   <= '0;
                match_cnt <= '0;
            end
            if (wr_en) begin
                wr_ptr  <= wr_ptr + 1'b1;
                entries <= (entries == FULL) ? FULL : entries + ONE;
                remain  <= (st == POST) ? remain - ONE : post_clamp - ONE;
                if (st == ARMED && trig_mode == 2'd2 && raw_match) match_cnt <= match_cnt + 8'd1;
                if (hit) trig_stamp <= stamp;
            end
            if (st == DONE) begin
                rd_data  <= mem[oldest];
                rd_ptr   <= oldest + 1'b1;
                rd_cnt   <= ONE;
                rd_last  <= entries == ONE;
                rd_valid <= 1'b1;
            end
            if (st == READOUT && xfer) begin
                rd_valid <= !rd_last;
                rd_last  <= !rd_last && (rd_cnt + ONE == entries);
                if (!rd_last) begin
                    rd_data <= mem[rd_ptr];
                    rd_ptr  <= rd_ptr + 1'b1;
                    rd_cnt  <= rd_cnt + ONE;
                end
            end
            if (abort) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb_pipeline_trace_buffer: directed capture scenarios; expected readout words are queued
// at stimulus time and checked by an independent monitor on each accepted transfer.
module tb_pipeline_trace_buffer;
    localparam int DW = 32, NC = 4, DEPTH = 64, TW = 16, AW = 6;
    localparam int CW = NC * DW, RW = CW + TW;

    logic clk = 0, reset = 0, sample_en = 0, arm = 0, abort = 0, rd_ready = 0;
    logic [CW-1:0] ch_data = '0;
    logic [1:0] trig_sel = '0, trig_mode = '0;
    logic [DW-1:0] trig_value = '0, trig_mask = '0;
    logic [7:0] trig_count = '0;
    logic [AW:0] post_count = '0;
    logic rd_valid, rd_last;
    logic [RW-1:0] rd_data;
    logic [2:0] state;
    logic [AW:0] entries;
    logic [TW-1:0] trig_stamp;

    int tests = 0, fails = 0, ns = 0;
    logic [TW-1:0] tcyc = '0;
    logic [TW-1:0] smp_stamp [0:1023];
    typedef struct packed { logic [RW-1:0] d; logic last; } exp_t;
    exp_t q[$];
    exp_t e;
    logic [RW-1:0] held;
    logic stalled = 0;

    pipeline_trace_buffer #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DEPTH), .TS_WIDTH(TW)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .ch_data(ch_data), .arm(arm),
        .abort(abort), .trig_sel(trig_sel), .trig_value(trig_value), .trig_mask(trig_mask),
        .trig_mode(trig_mode), .trig_count(trig_count), .post_count(post_count),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .state(state), .entries(entries), .trig_stamp(trig_stamp)
    );

    always #5 clk = ~clk;

    // Reference cycle stamp: counts edges since reset was released.
    always @(posedge clk) tcyc <= reset ? tcyc + 1'b1 : '0;

    // Channels: PC = 4*i, instr (BEQ every 5th from i=2), two pattern words.
    function automatic logic [CW-1:0] chv(input int i);
        logic [31:0] v = 32'(i);
        logic [31:0] instr = (i % 5 == 2) ? (32'h1000_0000 | v) : (32'h2000_0000 | v);
        return {~v, 32'hA5A5_0000 ^ v, instr, 32'(4 * i)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic step(input logic en);
        sample_en = en;
        ch_data = chv(ns);
        if (en) begin
            smp_stamp[ns] = tcyc;
            ns++;
        end
        @(posedge clk);
        #1;
        sample_en = 0;
        arm = 0;
        abort = 0;
    endtask

    task automatic do_arm(input logic [1:0] md, input logic [1:0] sel, input logic [31:0] val,
                          input logic [31:0] msk, input logic [7:0] cnt, input logic [AW:0] pc);
        trig_mode = md; trig_sel = sel; trig_value = val; trig_mask = msk;
        trig_count = cnt; post_count = pc;
        ns = 0;
        arm = 1;
        step(0);
        chk("armed state", 64'(state), 64'd1);
    endtask

    task automatic capture(input bit toggle, input int budget);
        for (int k = 0; k < budget; k++) begin
            step(toggle ? (k % 2 == 0) : 1'b1);
            if (state == 3'd3) break;
        end
        chk("reached DONE", 64'(state), 64'd3);
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) q.push_back({{smp_stamp[i], chv(i)}, i == hi});
    endtask

    task automatic drain(input int pct);
        for (int k = 0; k < 2000 && state != 3'd0; k++) begin
            rd_ready = ($urandom_range(0, 99) < pct);
            @(posedge clk);
            #1;
        end
        rd_ready = 0;
        chk("idle after last", 64'(state), 64'd0);
        chk("rd_valid after last", 64'(rd_valid), 64'd0);
        chk("all entries read", 64'(q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rd_valid && stalled) begin
            tests++;
            if (rd_data !== held) begin
                fails++;
                $display("FAIL stall hold: got %h want %h", rd_data, held);
            end
        end
        if (rd_valid && rd_ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL extra entry: got %h want none", rd_data);
            end else begin
                e = q.pop_front();
                if (rd_data !== e.d || rd_last !== e.last) begin
                    fails++;
                    $display("FAIL readout: got %h last %b want %h last %b", rd_data, rd_last, e.d, e.last);
                end
            end
        end
        stalled = reset && rd_valid && !rd_ready;
        held = rd_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset state", 64'(state), 64'd0);
        chk("reset rd_valid", 64'(rd_valid), 64'd0);
        chk("reset rd_last", 64'(rd_last), 64'd0);
        chk("reset entries", 64'(entries), 64'd0);
        chk("reset trig_stamp", 64'(trig_stamp), 64'd0);
        reset = 1;
        repeat (2) step(0);

        // Immediate trigger, 8-sample window
        do_arm(2'd0, 2'd0, 32'h0, 32'h0, 8'd0, 7'd8);
        capture(0, 20);
        chk("imm samples", 64'(ns), 64'd8);
        chk("imm entries", 64'(entries), 64'd8);
        chk("imm trig_stamp", 64'(trig_stamp), 64'(smp_stamp[0]));
        push_range(0, 7);
        drain(100);

        // Match on PC 0x190 (i=100), 16 post samples: wrapped buffer, trigger at entry 48
        do_arm(2'd1, 2'd0, 32'h190, 32'hFFFF_FFFF, 8'd0, 7'd16);
        capture(0, 200);
        chk("match samples", 64'(ns), 64'd116);
        chk("match entries", 64'(entries), 64'd64);
        chk("match trig_stamp", 64'(trig_stamp), 64'(smp_stamp[100]));
        push_range(52, 115);
        drain(30);

        // Third BEQ on the instr channel (i=2,7,12)
        do_arm(2'd2, 2'd1, 32'h1000_0000, 32'hFC00_0000, 8'd3, 7'd4);
        capture(0, 40);
        chk("nth samples", 64'(ns), 64'd16);
        chk("nth entries", 64'(entries), 64'd16);
        chk("nth trig_stamp", 64'(trig_stamp), 64'(smp_stamp[12]));
        push_range(0, 15);
        drain(100);

        // Stalled every other cycle: no writes on stalls
        do_arm(2'd0, 2'd0, 32'h0, 32'h0, 8'd0, 7'd5);
        capture(1, 40);
        chk("stall entries", 64'(entries), 64'd5);
        push_range(0, 4);
        drain(100);

        // Mismatch against PC 0 triggers on the second sample
        do_arm(2'd3, 2'd0, 32'h0, 32'hFFFF_FFFF, 8'd0, 7'd3);
        capture(0, 20);
        chk("mismatch entries", 64'(entries), 64'd4);
        chk("mismatch trig_stamp", 64'(trig_stamp), 64'(smp_stamp[1]));
        push_range(0, 3);
        drain(100);

        // post_count above DEPTH is clamped
        do_arm(2'd0, 2'd0, 32'h0, 32'h0, 8'd0, 7'd100);
        capture(0, 120);
        chk("clamp samples", 64'(ns), 64'd64);
        chk("clamp entries", 64'(entries), 64'd64);
        push_range(0, 63);
        drain(100);

        // Abort during POST, then arm+abort together
        do_arm(2'd0, 2'd0, 32'h0, 32'h0, 8'd0, 7'd10);
        repeat (3) step(1);
        chk("post before abort", 64'(state), 64'd2);
        abort = 1;
        step(0);
        chk("abort state", 64'(state), 64'd0);
        chk("abort rd_valid", 64'(rd_valid), 64'd0);
        arm = 1;
        abort = 1;
        step(0);
        chk("arm+abort state", 64'(state), 64'd0);

        // Reset during readout
        do_arm(2'd0, 2'd0, 32'h0, 32'h0, 8'd0, 7'd6);
        capture(0, 20);
        push_range(0, 5);
        rd_ready = 1;
        step(0);
        step(0);
        chk("readout before reset", 64'(state), 64'd4);
        rd_ready = 0;
        reset = 0;
        step(0);
        reset = 1;
        q.delete();
        chk("rst state", 64'(state), 64'd0);
        chk("rst rd_valid", 64'(rd_valid), 64'd0);
        chk("rst rd_last", 64'(rd_last), 64'd0);
        chk("rst entries", 64'(entries), 64'd0);
        chk("rst trig_stamp", 64'(trig_stamp), 64'd0);

        // Clean restart after reset
        do_arm(2'd1, 2'd0, 32'h20, 32'hFFFF_FFFF, 8'd0, 7'd2);
        capture(0, 40);
        chk("restart entries", 64'(entries), 64'd10);
        chk("restart trig_stamp", 64'(trig_stamp), 64'(smp_stamp[8]));
        push_range(0, 9);
        drain(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
